// File: rtl/crc_stream_engine.sv
// crc_stream_engine: streaming CRC generator / checker (MSB-first, non-reflected,
// no final XOR). Generate mode appends the CRC words to each frame; check mode
// forwards frames unchanged and reports the residue on the EOP output beat.
// Optional feature: define CRC_STREAM_ERRCNT_EN to add the saturating o_err_cnt
// output that counts check-mode CRC errors.
module crc_stream_engine #(
    parameter int                  DATAWIDTH  = 32,
    parameter int                  CRCWIDTH   = 32,
    parameter logic [CRCWIDTH-1:0] POLYNOMIAL = 32'h04C11DB7,
    parameter logic [CRCWIDTH-1:0] INIT       = 32'h52325032
) (
    input  logic                 reset,
    input  logic                 clk,
    input  logic                 i_mode,
    input  logic [DATAWIDTH-1:0] i_dat,
    input  logic                 i_val,
    input  logic                 i_sop,
    input  logic                 i_eop,
    output logic                 o_rdy,
    output logic [DATAWIDTH-1:0] o_dat,
    output logic                 o_val,
    output logic                 o_sop,
    output logic                 o_eop,
    input  logic                 i_rdy,
    output logic [CRCWIDTH-1:0]  o_crc,
    output logic                 o_err,
    output logic                 o_err_val
`ifdef CRC_STREAM_ERRCNT_EN
    ,
    output logic [15:0]          o_err_cnt
`endif
);

    localparam int NCRCW = CRCWIDTH / DATAWIDTH;
    localparam int IDXW  = (NCRCW > 1) ? $clog2(NCRCW) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCRCW - 1);

    // The CRC must split into whole stream words for the append phase.
    generate
        if ((CRCWIDTH % DATAWIDTH) != 0 || CRCWIDTH < 2) begin : g_width_check
            $error("crc_stream_engine: CRCWIDTH must be a multiple of DATAWIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        APPEND = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [CRCWIDTH-1:0]   crc_q, crc_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic                  val_q, val_d;
    logic [DATAWIDTH-1:0]  dat_q, dat_d;
    logic                  sop_q, sop_d;
    logic                  eop_q, eop_d;
    logic                  errv_q, errv_d;
    logic                  err_q, err_d;

    logic                  sink_beat;
    logic                  src_beat;
    logic                  out_free;
    logic                  frame_beat;
    logic                  mode_eff;
    logic [CRCWIDTH-1:0]   crc_calc;
    logic [CRCWIDTH-1:0]   crc_slice;

    // One word of the bit-serial CRC recurrence, data MSB first.
    function automatic logic [CRCWIDTH-1:0] crc_step(
        input logic [CRCWIDTH-1:0]  crc,
        input logic [DATAWIDTH-1:0] dat
    );
        logic [CRCWIDTH-1:0] r;
        logic                fb;
        r = crc;
        for (int i = DATAWIDTH - 1; i >= 0; i--) begin
            fb = r[CRCWIDTH-1] ^ dat[i];
            r  = {r[CRCWIDTH-2:0], 1'b0};
            if (fb) begin
                r = r ^ POLYNOMIAL;
            end
        end
        return r;
    endfunction

    assign out_free  = ~val_q | i_rdy;
    assign o_rdy     = out_free & (state_q != APPEND);
    assign sink_beat = i_val & o_rdy;
    assign src_beat  = val_q & i_rdy;
    // Outside a frame only a SOP beat is accepted into the stream; others are dropped.
    assign frame_beat = sink_beat & (i_sop | (state_q == DATA));
    assign mode_eff   = i_sop ? i_mode : mode_q;
    assign crc_calc   = crc_step(i_sop ? INIT : crc_q, i_dat);

    assign o_dat     = dat_q;
    assign o_val     = val_q;
    assign o_sop     = sop_q;
    assign o_eop     = eop_q;
    assign o_err     = err_q;
    assign o_err_val = errv_q;
    assign o_crc     = crc_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE and DATA share the frame-end rule; APPEND leaves after the last CRC word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DATA: begin
                if (frame_beat) begin
                    if (i_eop) begin
                        state_d = mode_eff ? IDLE : APPEND;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            APPEND: begin
                if (out_free && idx_q == IDX_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register, CRC and append index updates for the current state.
    always_comb begin
        val_d     = val_q;
        dat_d     = dat_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        errv_d    = errv_q;
        err_d     = err_q;
        mode_d    = mode_q;
        crc_d     = crc_q;
        idx_d     = idx_q;
        crc_slice = crc_q >> (DATAWIDTH * (NCRCW - 1 - int'(idx_q)));

        if (src_beat) begin
            val_d  = 1'b0;
            sop_d  = 1'b0;
            eop_d  = 1'b0;
            errv_d = 1'b0;
            err_d  = 1'b0;
        end

        if (frame_beat) begin
            crc_d  = crc_calc;
            if (i_sop) begin
                mode_d = i_mode;
            end
            val_d  = 1'b1;
            dat_d  = i_dat;
            sop_d  = i_sop;
            // Generate mode moves EOP onto the last appended CRC word.
            eop_d  = i_eop & mode_eff;
            errv_d = i_eop & mode_eff;
            err_d  = i_eop & mode_eff & (crc_calc != '0);
        end else if (state_q == APPEND && out_free) begin
            val_d  = 1'b1;
            dat_d  = crc_slice[DATAWIDTH-1:0];
            sop_d  = 1'b0;
            eop_d  = (idx_q == IDX_LAST);
            errv_d = 1'b0;
            err_d  = 1'b0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDXW'(1);
        end
    end

    // Datapath and output registers; reset discards any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_q  <= 1'b0;
            dat_q  <= '0;
            sop_q  <= 1'b0;
            eop_q  <= 1'b0;
            errv_q <= 1'b0;
            err_q  <= 1'b0;
            mode_q <= 1'b0;
            crc_q  <= INIT;
            idx_q  <= '0;
        end else begin
            val_q  <= val_d;
            dat_q  <= dat_d;
            sop_q  <= sop_d;
            eop_q  <= eop_d;
            errv_q <= errv_d;
            err_q  <= err_d;
            mode_q <= mode_d;
            crc_q  <= crc_d;
            idx_q  <= idx_d;
        end
    end

`ifdef CRC_STREAM_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Count each flagged check-mode EOP once, when it leaves the output register.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (src_beat && errv_q && err_q && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= 16'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: doc/crc_stream_engine.md
Name: crc_stream_engine

Overview:
- Sequential, streaming CRC generator/checker built on the team's per-word CRC update equation (MSB-first, non-reflected, no final XOR).
- Sits between the link-layer framer and the transport FIFO.
- Generate mode appends the CRC to each frame.
- Check mode passes frames through unchanged and flags a residue mismatch at end of frame.

Parameters:
- DATAWIDTH, 32, stream word width in bits.
- CRCWIDTH, 32, CRC width in bits. Must be an integer multiple of DATAWIDTH; elaboration fails otherwise.
- POLYNOMIAL, 32'h04C11DB7, generator polynomial, implicit top bit.
- INIT, 32'h52325032, CRC seed loaded at every start of packet (SOP).
- NCRCW (localparam) = CRCWIDTH/DATAWIDTH, number of CRC words per frame.

Ports:
- reset  in  1  asynchronous reset, active-high
- clk  in  1  clock
- i_mode  in  1  0 = generate (append CRC), 1 = check; sampled on each SOP beat
- i_dat  in  DATAWIDTH  sink data
- i_val  in  1  sink valid
- i_sop  in  1  sink start of frame
- i_eop  in  1  sink end of frame
- o_rdy  out  1  sink ready
- o_dat  out  DATAWIDTH  source data
- o_val  out  1  source valid
- o_sop  out  1  source start of frame
- o_eop  out  1  source end of frame
- i_rdy  in  1  source ready
- o_crc  out  CRCWIDTH  running CRC register
- o_err  out  1  check-mode CRC error, qualified by o_err_val
- o_err_val  out  1  one-cycle pulse on the check-mode EOP output beat

Behaviour:
- Reset: all outputs 0, o_crc = INIT, state IDLE, output register empty. reset may assert in any state, including mid-frame and mid-APPEND; the frame is discarded and no partial CRC is emitted.
- Beats: sink beat = i_val & o_rdy; source beat = o_val & i_rdy.
- Output stage: single register, latency 1. o_rdy = (~o_val | i_rdy) & (state != APPEND). The register loads on a sink beat or an APPEND emission; it clears o_val on a source beat with no new load.
- CRC update: crc_next = step(crc, i_dat), the bitwise MSB-first loop over DATAWIDTH bits. On a SOP beat, step(INIT, i_dat).
- State IDLE:
  - Sink beats without i_sop are consumed and dropped; o_crc is unchanged.
  - A SOP beat latches the mode, forwards the word with o_sop = 1, and goes to DATA. If i_eop is also set, the DATA exit rules below apply on the same beat.
- State DATA:
  - Every beat is forwarded and updates the CRC.
  - A beat with i_sop (restart) reseeds the CRC and re-latches the mode. The previous frame is abandoned: no append, no error pulse.
  - EOP beat, generate mode: forward the word with o_eop = 0, then go to APPEND.
  - EOP beat, check mode: forward the word with o_eop = 1 and go to IDLE. On that output beat, o_err_val = 1 and o_err = (crc_next != 0).
- State APPEND (generate only):
  - Sink is stalled.
  - Emit NCRCW words, MSB slice of the final CRC first. Each word advances only when the output register is free.
  - The last word carries o_eop = 1, then go to IDLE.
  - An index counter 0..NCRCW-1 wraps to 0 on exit.
- Simultaneous events:
  - SOP + EOP on one beat is a one-word frame. Generate mode appends step(INIT, w). Check mode tests the residue of the single word.
  - A check-mode frame shorter than NCRCW words is still judged by its residue only.
- o_crc holds its last value in IDLE until the next SOP.

Optional Feature:
- Macro: CRC_STREAM_ERRCNT_EN.
- Defined: adds output o_err_cnt [15:0]. It increments on each o_err_val & o_err, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Generate, DATAWIDTH = 8, CRCWIDTH = 8, POLYNOMIAL = 8'h07, INIT = 8'h00; frame "123456789" (8'h31..8'h39), i_rdy = 1 → output is the 9 bytes then 8'hF4 with o_eop = 1. o_sop is on the first byte only. o_rdy is low for exactly one cycle during APPEND.
- Check, same parameters; input 8'h31..8'h39, 8'hF4 → 10 words are passed through. o_err_val pulses with o_err = 0. The same frame with last word 8'hF5 gives o_err = 1.
- Generate, DATAWIDTH = 8, CRCWIDTH = 32, POLYNOMIAL = 32'h04C11DB7, INIT = 32'hFFFFFFFF; "123456789" → appended bytes are 8'h03, 8'h76, 8'hE6, 8'hE7. The last of these carries o_eop.
- Backpressure: i_rdy toggles 1/0 every cycle during the previous test → identical output sequence. No word is lost or duplicated, and o_dat is stable while o_val & ~i_rdy.
- Restart: SOP, 3 words, then a new SOP without an intervening EOP → the first frame gets no CRC word and no o_err_val. The second frame's CRC equals that of a standalone frame.
- Reset asserted during APPEND after 2 of 4 CRC words → o_val = 0 and o_crc = INIT immediately. The next frame is processed normally; with CRC_STREAM_ERRCNT_EN defined, o_err_cnt = 0.
